// File: rtl/posit_mul_arbiter.sv
// Round-robin front end sharing one pipelined posit multiplier among NREQ
// requesters, with tagged in-order result return through a credit FIFO.
module posit_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  parameter int TAGW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  output logic                  mul_valid,
  output logic [NBITS-1:0]      mul_a,
  output logic [NBITS-1:0]      mul_b,
  input  logic [NBITS-1:0]      mul_result,
  output logic [NREQ-1:0]       res_valid,
  output logic [NBITS-1:0]      res_data,
  input  logic [NREQ-1:0]       res_ready,
  output logic                  busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);
  localparam logic [TAGW-1:0] TLAST = TAGW'(NREQ - 1);

  logic [TAGW-1:0]  rr_q, rr_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LAT-1:0]   vld_q, vld_d;
  logic [TAGW-1:0]  tag_q [LAT];
  logic [TAGW-1:0]  tag_d [LAT];
  logic [NBITS-1:0] mem_q [DEPTH];
  logic [NBITS-1:0] mem_d [DEPTH];
  logic [TAGW-1:0]  ftag_q [DEPTH];
  logic [TAGW-1:0]  ftag_d [DEPTH];

  logic            win_vld;
  logic [TAGW-1:0] win;
  logic            issue;
  logic            wr;
  logic            pop;
  logic            empty;
  logic [TAGW-1:0] head;

  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_vld && req_valid[(int'(rr_q) + k) % NREQ]) begin
        win_vld = 1'b1;
        win     = TAGW'((int'(rr_q) + k) % NREQ);
      end
    end
  end

  // Credits cover both in-flight ops and FIFO entries, so writes never overflow.
  assign issue     = rst_n && win_vld && (outst_q < DEPTH_C);
  assign req_ready = issue ? (NREQ'(1) << win) : '0;
  assign mul_valid = issue;
  assign mul_a     = issue ? req_a[int'(win)*NBITS +: NBITS] : '0;
  assign mul_b     = issue ? req_b[int'(win)*NBITS +: NBITS] : '0;

  assign wr        = vld_q[LAT-1];
  assign empty     = (cnt_q == '0);
  assign head      = ftag_q[rptr_q];
  assign pop       = !empty && res_ready[head];
  assign res_valid = empty ? '0 : (NREQ'(1) << head);
  assign res_data  = empty ? '0 : mem_q[rptr_q];
  assign busy      = (outst_q != '0);

  always_comb begin
    rr_d    = rr_q;
    outst_d = outst_q + CW'(issue) - CW'(pop);
    cnt_d   = cnt_q + CW'(wr) - CW'(pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    ftag_d  = ftag_q;
    vld_d   = '0;
    tag_d   = tag_q;
    if (issue) begin
      rr_d = (win == TLAST) ? '0 : win + TAGW'(1);
    end
    vld_d[0] = issue;
    tag_d[0] = win;
    for (int k = 1; k < LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
    if (wr) begin
      mem_d[wptr_q]  = mul_result;
      ftag_d[wptr_q] = tag_q[LAT-1];
      wptr_d = (wptr_q == PLAST) ? '0 : wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PLAST) ? '0 : rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      outst_q <= '0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      vld_q   <= '0;
      for (int k = 0; k < LAT; k++) begin
        tag_q[k] <= '0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k]  <= '0;
        ftag_q[k] <= '0;
      end
    end else begin
      rr_q    <= rr_d;
      outst_q <= outst_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      mem_q   <= mem_d;
      ftag_q  <= ftag_d;
    end
  end

endmodule
